// File: rtl/four_bank_mem_resp_pkg.sv
// Shared constants and request decoding for the four-bank memory responder.
package four_bank_mem_resp_pkg;

   localparam int NUM_BANKS    = 4;
   localparam int BANK_SEL_LSB = 1;
   localparam int BANK_SEL_MSB = 2;
   localparam int BANK_IDX_W   = 2;

   localparam int DEF_ADDR_W   = 16;
   localparam int DEF_DATA_W   = 16;
   localparam int DEF_BANK_CYC = 4;
   localparam int DEF_RD_LAT   = 2;

   // Classification of the request presented in the current cycle.
   typedef enum logic [1:0] {
      REQ_NONE    = 2'd0,
      REQ_READ    = 2'd1,
      REQ_WRITE   = 2'd2,
      REQ_ILLEGAL = 2'd3
   } req_kind_e;

   // Read and write together, or an odd byte address, is illegal.
   function automatic req_kind_e decode_req(input logic rd, input logic wr, input logic addr_lsb);
      req_kind_e kind;
      case ({rd, wr})
         2'b00:   kind = REQ_NONE;
         2'b10:   kind = addr_lsb ? REQ_ILLEGAL : REQ_READ;
         2'b01:   kind = addr_lsb ? REQ_ILLEGAL : REQ_WRITE;
         default: kind = REQ_ILLEGAL;
      endcase
      return kind;
   endfunction

endpackage

// File: rtl/four_bank_mem_resp_if.sv
// Request/response bundle between the cache controller (master) and the memory (slave).
interface four_bank_mem_resp_if
   import four_bank_mem_resp_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) ();

   logic [ADDR_W-1:0]    addr;
   logic [DATA_W-1:0]    data_in;
   logic                 wr;
   logic                 rd;
   logic [DATA_W-1:0]    data_out;
   logic                 rd_valid;
   logic                 stall;
   logic [NUM_BANKS-1:0] busy;
   logic                 err;

   modport master (
      output addr, data_in, wr, rd,
      input  data_out, rd_valid, stall, busy, err
   );

   modport slave (
      input  addr, data_in, wr, rd,
      output data_out, rd_valid, stall, busy, err
   );

endinterface

// File: rtl/four_bank_mem_resp_bank_timer.sv
// Per-bank occupancy timer. The counter loads BANK_CYC on an accept and
// counts down; the bank may accept again in the cycle its counter steps
// from 1 to 0, so consecutive accepts to one bank are BANK_CYC cycles apart.
module four_bank_mem_resp_bank_timer
   import four_bank_mem_resp_pkg::*;
#(
   parameter int BANK_CYC = DEF_BANK_CYC
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   output logic busy_o
);

   localparam int              CNT_W    = $clog2(BANK_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BANK_CYC);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             busy_q;
   logic             busy_d;

   // Next counter value: load on accept, otherwise count down and stop at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = CNT_LOAD;
      end else if (cnt_q != CNT_ZERO) begin
         cnt_d = cnt_q - CNT_ONE;
      end else begin
         cnt_d = CNT_ZERO;
      end
      busy_d = (cnt_d > CNT_ONE);
   end

   // Counter and registered busy flag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q  <= CNT_ZERO;
         busy_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   assign busy_o = busy_q;

endmodule

// File: rtl/four_bank_mem_resp.sv
// Word-addressed main-memory model with four interleaved banks (bank = addr[2:1]),
// per-bank occupancy, request stall/err decode and a fixed-latency read pipeline.
module four_bank_mem_resp
   import four_bank_mem_resp_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int BANK_CYC = DEF_BANK_CYC,
   parameter int RD_LAT   = DEF_RD_LAT
) (
   input  logic                clk_i,
   input  logic                rst_i,
   four_bank_mem_resp_if.slave bus
);

   localparam int WORD_W = ADDR_W - 1;
   localparam int DEPTH  = 2 ** WORD_W;

   logic [DATA_W-1:0]     mem_q [DEPTH];
   logic [RD_LAT-1:0]     vld_q;
   logic [DATA_W-1:0]     dat_q [RD_LAT];

   req_kind_e             kind_s;
   logic [BANK_IDX_W-1:0] bank_s;
   logic [WORD_W-1:0]     word_s;
   logic [NUM_BANKS-1:0]  busy_s;
   logic [NUM_BANKS-1:0]  load_s;
   logic                  err_s;
   logic                  stall_s;
   logic                  acc_rd_s;
   logic                  acc_wr_s;

   // Request decode: illegal requests raise err, a busy target bank raises stall,
   // otherwise the request is accepted and the target bank timer is loaded.
   always_comb begin
      kind_s   = decode_req(bus.rd, bus.wr, bus.addr[0]);
      bank_s   = bus.addr[BANK_SEL_MSB:BANK_SEL_LSB];
      word_s   = bus.addr[ADDR_W-1:1];
      err_s    = 1'b0;
      stall_s  = 1'b0;
      acc_rd_s = 1'b0;
      acc_wr_s = 1'b0;
      load_s   = {NUM_BANKS{1'b0}};
      if (rst_i) begin
         err_s   = 1'b0;
         stall_s = 1'b0;
      end else begin
         case (kind_s)
            REQ_READ: begin
               if (busy_s[bank_s]) begin
                  stall_s = 1'b1;
               end else begin
                  acc_rd_s = 1'b1;
               end
            end
            REQ_WRITE: begin
               if (busy_s[bank_s]) begin
                  stall_s = 1'b1;
               end else begin
                  acc_wr_s = 1'b1;
               end
            end
            REQ_ILLEGAL: err_s = 1'b1;
            REQ_NONE:    err_s = 1'b0;
            default:     err_s = 1'b0;
         endcase
         load_s[bank_s] = acc_rd_s | acc_wr_s;
      end
   end

   // One occupancy timer per bank.
   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
      four_bank_mem_resp_bank_timer #(
         .BANK_CYC (BANK_CYC)
      ) u_timer (
         .clk_i  (clk_i),
         .rst_i  (rst_i),
         .load_i (load_s[g]),
         .busy_o (busy_s[g])
      );
   end

   // Storage: updated at the accept edge of a write; contents survive reset.
   always_ff @(posedge clk_i) begin
      if (acc_wr_s) begin
         mem_q[word_s] <= bus.data_in;
      end
   end

   // Read pipeline: stage 0 samples storage at the accept edge, later stages shift.
   // Non-read slots carry zero data so data_out is zero whenever rd_valid is low.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_q <= {RD_LAT{1'b0}};
         for (int i = 0; i < RD_LAT; i++) begin
            dat_q[i] <= {DATA_W{1'b0}};
         end
      end else begin
         vld_q[0] <= acc_rd_s;
         dat_q[0] <= acc_rd_s ? mem_q[word_s] : {DATA_W{1'b0}};
         for (int i = 1; i < RD_LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            dat_q[i] <= dat_q[i-1];
         end
      end
   end

   assign bus.data_out = dat_q[RD_LAT-1];
   assign bus.rd_valid = vld_q[RD_LAT-1];
   assign bus.busy     = busy_s;
   assign bus.stall    = stall_s;
   assign bus.err      = err_s;

endmodule
